// File: rtl/jt51_phinc_pkg.sv
// Shared types and widths for the phase-increment ROM arbiter.
// Keycode/phinc widths match the jt51 phase generator ROM.
package jt51_phinc_pkg;

    localparam int KC_W    = 10;
    localparam int PHINC_W = 12;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } phinc_tag_t;

endpackage

// File: rtl/jt51_phinc_if.sv
// Request/result bundle for the two phinc ROM requesters.
// master = requester side, slave = arbiter side.
interface jt51_phinc_if;
    import jt51_phinc_pkg::*;

    logic               req_a;
    logic [KC_W-1:0]    kc_a;
    logic               gnt_a;
    logic               vld_a;
    logic [PHINC_W-1:0] phinc_a;

    logic               req_b;
    logic [KC_W-1:0]    kc_b;
    logic               gnt_b;
    logic               vld_b;
    logic [PHINC_W-1:0] phinc_b;

    modport master (
        output req_a, kc_a, req_b, kc_b,
        input  gnt_a, vld_a, phinc_a,
        input  gnt_b, vld_b, phinc_b
    );

    modport slave (
        input  req_a, kc_a, req_b, kc_b,
        output gnt_a, vld_a, phinc_a,
        output gnt_b, vld_b, phinc_b
    );

endinterface

// File: rtl/jt51_phinc_rr_arb.sv
// Two-way arbiter: round-robin, or fixed A priority with a
// starvation escape for B. Winner is combinational.
module jt51_phinc_rr_arb
    import jt51_phinc_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_a,
    input  logic       req_b,
    output logic       win_vld,
    output phinc_tag_t win
);

    phinc_tag_t       rr_last_q, rr_last_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starve_hit;

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_comb begin
        win_vld = req_a | req_b;
        win     = TAG_A;
        if (req_a && req_b) begin
            if (FIXED_PRIO)
                win = starve_hit ? TAG_B : TAG_A;
            else
                win = (rr_last_q == TAG_A) ? TAG_B : TAG_A;
        end else if (req_b) begin
            win = TAG_B;
        end
    end

    always_comb begin
        rr_last_d    = win_vld ? win : rr_last_q;
        starve_cnt_d = '0;
        // Only a B request that loses to A moves the counter
        if (FIXED_PRIO && req_b && win == TAG_A) begin
            starve_cnt_d = starve_hit ? starve_cnt_q
                                      : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q    <= TAG_B;
            starve_cnt_q <= '0;
        end else if (cen) begin
            rr_last_q    <= rr_last_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/jt51_phinc_arb.sv
// Shares one phinc ROM between two requesters: arbitration,
// registered ROM address, and tagged result capture.
module jt51_phinc_arb
    import jt51_phinc_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jt51_phinc_if.slave        bus,
    output logic [KC_W-1:0]    rom_keycode,
    input  logic [PHINC_W-1:0] rom_phinc
);

    logic       win_vld;
    phinc_tag_t win;

    jt51_phinc_rr_arb #(
        .FIXED_PRIO (FIXED_PRIO),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .req_a   (bus.req_a),
        .req_b   (bus.req_b),
        .win_vld (win_vld),
        .win     (win)
    );

    logic [KC_W-1:0]    rom_keycode_q, rom_keycode_d;
    phinc_tag_t         s1_tag_q, s1_tag_d;
    logic               s1_vld_q, s1_vld_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               vld_a_q, vld_a_d;
    logic               vld_b_q, vld_b_d;
    logic [PHINC_W-1:0] phinc_a_q, phinc_a_d;
    logic [PHINC_W-1:0] phinc_b_q, phinc_b_d;

    always_comb begin
        rom_keycode_d = rom_keycode_q;
        s1_tag_d      = s1_tag_q;
        s1_vld_d      = win_vld;
        gnt_a_d       = win_vld && (win == TAG_A);
        gnt_b_d       = win_vld && (win == TAG_B);
        if (win_vld) begin
            rom_keycode_d = (win == TAG_B) ? bus.kc_b : bus.kc_a;
            s1_tag_d      = win;
        end
        // Capture runs regardless of what stage 0 does this cycle
        vld_a_d   = s1_vld_q && (s1_tag_q == TAG_A);
        vld_b_d   = s1_vld_q && (s1_tag_q == TAG_B);
        phinc_a_d = vld_a_d ? rom_phinc : phinc_a_q;
        phinc_b_d = vld_b_d ? rom_phinc : phinc_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_keycode_q <= '0;
            s1_tag_q      <= TAG_A;
            s1_vld_q      <= 1'b0;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            vld_a_q       <= 1'b0;
            vld_b_q       <= 1'b0;
            phinc_a_q     <= '0;
            phinc_b_q     <= '0;
        end else if (cen) begin
            rom_keycode_q <= rom_keycode_d;
            s1_tag_q      <= s1_tag_d;
            s1_vld_q      <= s1_vld_d;
            gnt_a_q       <= gnt_a_d;
            gnt_b_q       <= gnt_b_d;
            vld_a_q       <= vld_a_d;
            vld_b_q       <= vld_b_d;
            phinc_a_q     <= phinc_a_d;
            phinc_b_q     <= phinc_b_d;
        end
    end

    assign rom_keycode = rom_keycode_q;
    assign bus.gnt_a   = gnt_a_q;
    assign bus.gnt_b   = gnt_b_q;
    assign bus.vld_a   = vld_a_q;
    assign bus.vld_b   = vld_b_q;
    assign bus.phinc_a = phinc_a_q;
    assign bus.phinc_b = phinc_b_q;

endmodule

// File: tb/tb_jt51_phinc_arb.sv
// Directed bench for jt51_phinc_arb: round-robin instance (dut0)
// and fixed-priority instance (dut1), each with an identity ROM.
module tb_jt51_phinc_arb;

    logic       clk;
    logic       rst_n;
    logic       cen;
    logic [9:0] rk0, rk1;
    logic [11:0] rp0, rp1;
    int         checks;
    int         errors;

    jt51_phinc_if ifc0();
    jt51_phinc_if ifc1();

    jt51_phinc_arb #(.FIXED_PRIO(1'b0), .STARVE_MAX(7), .CNT_W(3)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .bus         (ifc0),
        .rom_keycode (rk0),
        .rom_phinc   (rp0)
    );

    jt51_phinc_arb #(.FIXED_PRIO(1'b1), .STARVE_MAX(7), .CNT_W(3)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .bus         (ifc1),
        .rom_keycode (rk1),
        .rom_phinc   (rp1)
    );

    assign rp0 = {2'b00, rk0};
    assign rp1 = {2'b00, rk1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare {gnt_a,gnt_b,vld_a,vld_b} of one instance
    task automatic outs(input int d, input string tag,
                        input logic ga, input logic gb,
                        input logic va, input logic vb);
        logic [3:0] obs;
        if (d == 0)
            obs = {ifc0.gnt_a, ifc0.gnt_b, ifc0.vld_a, ifc0.vld_b};
        else
            obs = {ifc1.gnt_a, ifc1.gnt_b, ifc1.vld_a, ifc1.vld_b};
        chk(tag, {8'h00, obs}, {8'h00, ga, gb, va, vb});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc0.req_a = 1'b0; ifc0.req_b = 1'b0;
        ifc1.req_a = 1'b0; ifc1.req_b = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [9:0] e;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        cen    = 1'b1;
        idle();
        ifc0.kc_a = '0; ifc0.kc_b = '0;
        ifc1.kc_a = '0; ifc1.kc_b = '0;

        // Test 1: reset with random stimulus, then first lookup
        for (int i = 0; i < 3; i++) begin
            ifc0.req_a = 1'($urandom_range(1));
            ifc0.req_b = 1'($urandom_range(1));
            ifc0.kc_a  = 10'($urandom);
            ifc0.kc_b  = 10'($urandom);
            step();
            outs(0, "rst.pulses", 0, 0, 0, 0);
            chk("rst.phinc_a", ifc0.phinc_a, 12'h000);
            chk("rst.phinc_b", ifc0.phinc_b, 12'h000);
            chk("rst.rom_kc", {2'b00, rk0}, 12'h000);
        end
        rst_n = 1'b1;
        idle();
        ifc0.req_a = 1'b1;
        ifc0.kc_a  = 10'h155;
        step();
        outs(0, "t1.gnt", 1, 0, 0, 0);
        chk("t1.rom_kc", {2'b00, rk0}, 12'h155);
        ifc0.req_a = 1'b0;
        step();
        outs(0, "t1.vld", 0, 0, 1, 0);
        chk("t1.phinc_a", ifc0.phinc_a, 12'h155);
        step();
        outs(0, "t1.idle", 0, 0, 0, 0);
        chk("t1.hold", ifc0.phinc_a, 12'h155);

        // Test 2: round-robin with both requesting
        do_reset();
        ifc0.req_a = 1'b1; ifc0.kc_a = 10'h011;
        ifc0.req_b = 1'b1; ifc0.kc_b = 10'h022;
        step();
        outs(0, "t2.c1", 1, 0, 0, 0);
        ifc0.kc_a = 10'h013;
        step();
        outs(0, "t2.c2", 0, 1, 1, 0);
        chk("t2.c2.pa", ifc0.phinc_a, 12'h011);
        ifc0.kc_b = 10'h024;
        step();
        outs(0, "t2.c3", 1, 0, 0, 1);
        chk("t2.c3.pb", ifc0.phinc_b, 12'h022);
        step();
        outs(0, "t2.c4", 0, 1, 1, 0);
        chk("t2.c4.pa", ifc0.phinc_a, 12'h013);
        idle();
        step();
        outs(0, "t2.c5", 0, 0, 0, 1);
        chk("t2.c5.pb", ifc0.phinc_b, 12'h024);

        // Test 3: fixed priority, B forced after 7 losses
        do_reset();
        ifc1.req_a = 1'b1; ifc1.kc_a = 10'h100;
        ifc1.req_b = 1'b1; ifc1.kc_b = 10'h2AA;
        for (int i = 1; i <= 17; i++) begin
            step();
            outs(1, $sformatf("t3.c%0d", i),
                 (i % 8) != 0, (i % 8) == 0,
                 i > 1 && (i % 8) != 1, i > 1 && (i % 8) == 1);
            if (i == 9 || i == 17)
                chk("t3.pb", ifc1.phinc_b, 12'h2AA);
        end
        chk("t3.pa", ifc1.phinc_a, 12'h100);
        idle();

        // Test 4: cen gating stretches pulses
        do_reset();
        ifc0.req_a = 1'b1; ifc0.kc_a = 10'h0F0;
        step();
        outs(0, "t4.e1", 1, 0, 0, 0);
        ifc0.req_a = 1'b0;
        cen = 1'b0;
        step();
        outs(0, "t4.off1", 1, 0, 0, 0);
        step();
        outs(0, "t4.off2", 1, 0, 0, 0);
        chk("t4.off2.pa", ifc0.phinc_a, 12'h000);
        cen = 1'b1;
        step();
        outs(0, "t4.e2", 0, 0, 1, 0);
        chk("t4.e2.pa", ifc0.phinc_a, 12'h0F0);
        cen = 1'b0;
        step();
        outs(0, "t4.off3", 0, 0, 1, 0);
        cen = 1'b1;
        step();
        outs(0, "t4.e3", 0, 0, 0, 0);

        // Test 5: reset right after gnt_b drops the lookup
        do_reset();
        ifc0.req_b = 1'b1; ifc0.kc_b = 10'h0AB;
        step();
        outs(0, "t5.gnt", 0, 1, 0, 0);
        ifc0.req_b = 1'b0;
        rst_n = 1'b0;
        #1;
        outs(0, "t5.async", 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            outs(0, "t5.after", 0, 0, 0, 0);
            chk("t5.pb", ifc0.phinc_b, 12'h000);
        end
        ifc0.req_a = 1'b1; ifc0.kc_a = 10'h033;
        ifc0.req_b = 1'b1; ifc0.kc_b = 10'h044;
        step();
        outs(0, "t5.first", 1, 0, 0, 0);
        idle();
        step();
        chk("t5.pa", ifc0.phinc_a, 12'h033);

        // Test 6: 32 back-to-back lookups across keycode wrap
        do_reset();
        ifc0.kc_a = 10'h3F0;
        for (int i = 0; i <= 32; i++) begin
            ifc0.req_a = (i < 32);
            step();
            if (i < 32) begin
                chk("t6.gnt", {11'h000, ifc0.gnt_a}, 12'h001);
                ifc0.kc_a = ifc0.kc_a + 10'd1;
            end
            if (i > 0) begin
                e = 10'h3F0 + 10'(i - 1);
                chk("t6.vld", {11'h000, ifc0.vld_a}, 12'h001);
                chk("t6.phinc", ifc0.phinc_a, {2'b00, e});
            end
        end
        step();
        outs(0, "t6.end", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
